mem_lsu: RTL and testbench

// MEM stage, directly downstream of the EX/MEM pipeline register and upstream of MEM/WB.

---
 rtl/mem_lsu.sv | 248 ++++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: MEM pipeline stage. Passes writeback info through and runs loads/stores on a req/ack bus.
// Optional MEM_ALIGN_CHECK_EN: misaligned half/word accesses are rejected with mem_err instead of issued.

module mem_lsu #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic        mem_whilo,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  input  logic        pipe_stall,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        wb_whilo,
  output logic [31:0] wb_hi,
  output logic [31:0] wb_lo,
  output logic        stallreq,
  output logic        mem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  localparam logic [7:0] TIMEOUT_C = 8'(BUS_TIMEOUT);

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic [31:0] rdata_r;
  logic        err_r;

  logic        is_load_s;
  logic        is_store_s;
  logic        sext_s;
  size_t       size_s;
  logic        mem_acc_s;
  logic        misalign_s;
  logic        access_s;

  // Big-endian lane enables; half/word ignore the low address bits they do not use.
  function automatic logic [3:0] lane_sel_f(input size_t sz, input logic [1:0] a);
    logic [3:0] sel;
    case (sz)
      SZ_BYTE: sel = 4'b1000 >> a;
      SZ_HALF: sel = a[1] ? 4'b0011 : 4'b1100;
      SZ_WORD: sel = 4'b1111;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] store_data_f(input size_t sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      SZ_WORD: r = d;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_data_f(input size_t sz, input logic sext,
                                              input logic [1:0] a, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = a[1] ? d[15:0] : d[31:16];
    case (sz)
      SZ_BYTE: r = {{24{sext & b[7]}}, b};
      SZ_HALF: r = {{16{sext & h[15]}}, h};
      SZ_WORD: r = d;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Decode the memory opcode into direction, access size and sign handling.
  always_comb begin
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    sext_s     = 1'b0;
    size_s     = SZ_BYTE;
    case (mem_op)
      4'd1: begin is_load_s  = 1'b1; sext_s = 1'b1; size_s = SZ_BYTE; end
      4'd2: begin is_load_s  = 1'b1;                size_s = SZ_BYTE; end
      4'd3: begin is_load_s  = 1'b1; sext_s = 1'b1; size_s = SZ_HALF; end
      4'd4: begin is_load_s  = 1'b1;                size_s = SZ_HALF; end
      4'd5: begin is_load_s  = 1'b1;                size_s = SZ_WORD; end
      4'd6: begin is_store_s = 1'b1;                size_s = SZ_BYTE; end
      4'd7: begin is_store_s = 1'b1;                size_s = SZ_HALF; end
      4'd8: begin is_store_s = 1'b1;                size_s = SZ_WORD; end
      default: begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
      end
    endcase
  end

  assign mem_acc_s = is_load_s | is_store_s;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = mem_acc_s &
                      (((size_s == SZ_HALF) & mem_addr[0]) |
                       ((size_s == SZ_WORD) & (mem_addr[1:0] != 2'b00)));
`else
  assign misalign_s = 1'b0;
`endif

  assign access_s = mem_acc_s & ~misalign_s;

  // Access sequencer: issue, wait for ack/err/timeout, then hold the result until MEM/WB advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      rdata_r <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (access_s) begin
            state_r <= ST_BUSY;
            cnt_r   <= 8'd1;
            err_r   <= 1'b0;
          end
        end
        ST_BUSY: begin
          // An error wins over a simultaneous ack; an ack wins over a timeout in the same cycle.
          if (bus_err) begin
            err_r   <= 1'b1;
            state_r <= ST_DONE;
          end else if (bus_ack) begin
            rdata_r <= bus_rdata;
            err_r   <= 1'b0;
            state_r <= ST_DONE;
          end else if (cnt_r == TIMEOUT_C) begin
            err_r   <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            cnt_r   <= cnt_r + 8'd1;
          end
        end
        ST_DONE: begin
          if (!pipe_stall) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Output decode: zero-latency pass-through when idle, bus drive while accessing, result in DONE.
  always_comb begin
    wb_wd     = 5'd0;
    wb_wreg   = 1'b0;
    wb_wdata  = 32'h0000_0000;
    wb_whilo  = 1'b0;
    wb_hi     = 32'h0000_0000;
    wb_lo     = 32'h0000_0000;
    stallreq  = 1'b0;
    mem_err   = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'h0000_0000;
    bus_sel   = 4'b0000;
    bus_wdata = 32'h0000_0000;
    if (rst) begin
      bus_req = 1'b0;
    end else begin
      wb_wd    = mem_wd;
      wb_wdata = mem_wdata;
      wb_hi    = mem_hi;
      wb_lo    = mem_lo;
      case (state_r)
        ST_IDLE: begin
          if (access_s) begin
            stallreq = 1'b1;
            bus_req  = 1'b1;
          end else if (misalign_s) begin
            mem_err  = 1'b1;
          end else begin
            wb_wreg  = mem_wreg;
            wb_whilo = mem_whilo;
          end
        end
        ST_BUSY: begin
          stallreq = 1'b1;
          bus_req  = 1'b1;
        end
        ST_DONE: begin
          if (err_r) begin
            mem_err = 1'b1;
          end else if (is_load_s) begin
            wb_wdata = load_data_f(size_s, sext_s, mem_addr[1:0], rdata_r);
            wb_wreg  = mem_wreg;
            wb_whilo = mem_whilo;
          end else begin
            wb_whilo = mem_whilo;
          end
        end
        default: begin
          bus_req = 1'b0;
        end
      endcase
      if (bus_req) begin
        bus_we    = is_store_s;
        bus_addr  = {mem_addr[31:2], 2'b00};
        bus_sel   = lane_sel_f(size_s, mem_addr[1:0]);
        bus_wdata = is_store_s ? store_data_f(size_s, mem_sdata) : 32'h0000_0000;
      end else begin
        bus_we    = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu: a transaction-level model predicts bus drive, latency and writeback.
module tb_mem_lsu;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        pipe_stall;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        stallreq;
  logic        mem_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_lsu #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_sdata(mem_sdata), .pipe_stall(pipe_stall),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .wb_whilo(wb_whilo),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .stallreq(stallreq), .mem_err(mem_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic int op_bytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  // kind: 0 ack, 1 err, 2 ack+err, given in BUSY cycle k (k > TO means no response at all)
  task automatic txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                     input logic [31:0] wdata, input logic [4:0] wd, input logic wreg,
                     input logic whilo, input int k, input int kind, input int stalls,
                     input logic [31:0] ack_data);
    int n, a, off, done_c;
    bit ld, sgn, err_exp;
    logic [3:0]  sel;
    logic [31:0] exp_wd;
    logic [63:0] v;
    mem_op = op; mem_addr = addr; mem_sdata = sdata; mem_wdata = wdata;
    mem_wd = wd; mem_wreg = wreg; mem_whilo = whilo;
    mem_hi = $urandom; mem_lo = $urandom; pipe_stall = 1'b0;
    bus_ack = 1'($urandom_range(0, 1)); bus_err = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    n = op_bytes(op);
    ld = (op >= 4'd1) && (op <= 4'd5);
    sgn = (op == 4'd1) || (op == 4'd3);
    sample();
    check_eq("hi_pass", wb_hi, mem_hi);
    check_eq("lo_pass", wb_lo, mem_lo);
    if (n == 0) begin
      check_eq("none_wd", wb_wd, wd);
      check_eq("none_wreg", wb_wreg, wreg);
      check_eq("none_wdata", wb_wdata, wdata);
      check_eq("none_whilo", wb_whilo, whilo);
      check_eq("none_stall", stallreq, 32'd0);
      check_eq("none_req", bus_req, 32'd0);
      check_eq("none_err", mem_err, 32'd0);
      step();
      return;
    end
    a = int'(addr[1:0]);
    off = a - (a % n);
`ifdef MEM_ALIGN_CHECK_EN
    if ((a % n) != 0) begin
      check_eq("mis_req", bus_req, 32'd0);
      check_eq("mis_stall", stallreq, 32'd0);
      check_eq("mis_err", mem_err, 32'd1);
      check_eq("mis_wreg", wb_wreg, 32'd0);
      step();
      return;
    end
`endif
    sel = 4'b0000;
    for (int i = off; i < off + n; i++) sel[3 - i] = 1'b1;
    check_eq("idle_req", bus_req, 32'd1);
    check_eq("idle_stall", stallreq, 32'd1);
    check_eq("idle_err", mem_err, 32'd0);
    check_eq("bus_we", bus_we, ld ? 32'd0 : 32'd1);
    check_eq("bus_addr", bus_addr, addr - 32'(a));
    check_eq("bus_sel", bus_sel, sel);
    if (!ld) begin
      if (n == 4) exp_wd = sdata;
      else if (n == 2) exp_wd = (sdata % 65536) * 32'h0001_0001;
      else exp_wd = (sdata % 256) * 32'h0101_0101;
      check_eq("bus_wdata", bus_wdata, exp_wd);
    end
    done_c  = (k <= int'(TO)) ? k : int'(TO);
    err_exp = (k > int'(TO)) || (kind != 0);
    for (int c = 1; c <= done_c; c++) begin
      step();
      bus_ack   = (c == k) && (kind != 1);
      bus_err   = (c == k) && (kind != 0);
      bus_rdata = (c == k) ? ack_data : $urandom;
      sample();
      check_eq("busy_req", bus_req, 32'd1);
      check_eq("busy_stall", stallreq, 32'd1);
    end
    step();
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
    pipe_stall = (stalls > 0);
    v = {32'h0, ack_data} >> (8 * (4 - off - n));
    if (n < 4) begin
      v = v & ((64'd1 << (8 * n)) - 64'd1);
      if (sgn && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
    end
    for (int s = 0; s <= stalls; s++) begin
      if (s > 0) begin
        step();
        pipe_stall = (s < stalls);
      end
      sample();
      check_eq("done_req", bus_req, 32'd0);
      check_eq("done_stall", stallreq, 32'd0);
      check_eq("done_err", mem_err, err_exp ? 32'd1 : 32'd0);
      check_eq("done_wd", wb_wd, wd);
      check_eq("done_wreg", wb_wreg, (err_exp || !ld) ? 32'd0 : 32'(wreg));
      check_eq("done_whilo", wb_whilo, err_exp ? 32'd0 : 32'(whilo));
      if (ld && !err_exp) check_eq("load_data", wb_wdata, v[31:0]);
    end
    step();
  endtask

  initial begin
    rst = 1'b1;
    mem_op = 4'd0; mem_addr = 32'h0; mem_sdata = 32'h0; mem_wdata = 32'h1357_9bdf;
    mem_wd = 5'd7; mem_wreg = 1'b1; mem_whilo = 1'b1; mem_hi = 32'hdead_beef; mem_lo = 32'h1;
    pipe_stall = 1'b0; bus_rdata = 32'h0; bus_ack = 1'b0; bus_err = 1'b0;
    step();
    step();
    sample();
    check_eq("rst_wd", wb_wd, 32'd0);
    check_eq("rst_wreg", wb_wreg, 32'd0);
    check_eq("rst_wdata", wb_wdata, 32'd0);
    check_eq("rst_hi", wb_hi, 32'd0);
    check_eq("rst_req", bus_req, 32'd0);
    check_eq("rst_stall", stallreq, 32'd0);
    step();
    rst = 1'b0;

    // Directed cases first, then random traffic
    txn(4'd0, 32'h0000_0100, 32'h0, 32'h0000_1234, 5'd5, 1'b1, 1'b0, 1, 0, 0, 32'h0);
    txn(4'd1, 32'h0000_0101, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 2, 0, 0, 32'h0080_0000);
    txn(4'd7, 32'h0000_0102, 32'h0000_abcd, 32'h0, 5'd4, 1'b1, 1'b0, 1, 0, 1, 32'h0);
    txn(4'd5, 32'h0000_0040, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 99, 0, 0, 32'h0);
    txn(4'd5, 32'h0000_0002, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0, 1, 0, 0, 32'h1122_3344);
    txn(4'd3, 32'h0000_0200, 32'h0, 32'h0, 5'd11, 1'b1, 1'b1, 3, 1, 2, 32'hffff_0000);
    txn(4'd2, 32'h0000_0203, 32'h0, 32'h0, 5'd12, 1'b1, 1'b0, 2, 2, 0, 32'h0000_00ff);
    txn(4'd4, 32'h0000_0302, 32'h0, 32'h0, 5'd13, 1'b1, 1'b0, 4, 0, 0, 32'h1234_8765);

    // Reset while a load is outstanding
    mem_op = 4'd5; mem_addr = 32'h0000_0080; mem_wreg = 1'b1; bus_ack = 1'b0; bus_err = 1'b0;
    sample();
    check_eq("mid_idle_req", bus_req, 32'd1);
    step();
    sample();
    check_eq("mid_busy_req", bus_req, 32'd1);
    step();
    rst = 1'b1;
    mem_op = 4'd0; mem_addr = 32'h0; mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'h0;
    mem_whilo = 1'b0; mem_hi = 32'h0; mem_lo = 32'h0;
    sample();
    check_eq("mid_rst_req", bus_req, 32'd0);
    check_eq("mid_rst_stall", stallreq, 32'd0);
    step();
    rst = 1'b0;
    bus_ack = 1'b1; bus_rdata = $urandom;
    sample();
    check_eq("post_rst_req", bus_req, 32'd0);
    check_eq("post_rst_stall", stallreq, 32'd0);
    check_eq("post_rst_err", mem_err, 32'd0);
    check_eq("post_rst_wreg", wb_wreg, 32'd0);
    check_eq("post_rst_wdata", wb_wdata, 32'd0);
    step();
    bus_ack = 1'b0;

    for (int t = 0; t < 120; t++) begin
      int r;
      r = $urandom_range(0, 9);
      txn(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 6),
          (r < 7) ? 0 : ((r < 9) ? 1 : 2), $urandom_range(0, 2), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
